alu_mw_sequencer: RTL
=====================

Name: alu_mw_sequencer

Overview:
Multi-cycle controller that sequences the shared 32-bit ALU to perform WORDS×32-bit add/subtract, one word per clock, least-significant word first. It chains the carry through ADC (ALUControl 4'b0101, C_in) and accumulates full-width NZCV flags. It sits between the execute-stage issue logic and the ALU: a valid/ready request in, a valid/ready response out, and an ALU operand/control bus driven while running.

Parameters:
WORDS, 2, number of 32-bit words per operand (legal 2..4)

Ports:
CLK  input  1  clock, rising-edge
Reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request (high only in IDLE)
req_op  input  1  0 = add (A+B), 1 = subtract (A−B)
req_a  input  32*WORDS  operand A, word 0 = bits [31:0]
req_b  input  32*WORDS  operand B
resp_valid  output  1  result and flags valid
resp_ready  input  1  consumer accepts response
resp_result  output  32*WORDS  sum/difference
resp_flags  output  4  {N,Z,C,V} of the full-width result
busy  output  1  high in RUN or DONE
alu_src_a  output  32  to ALU Src_A
alu_src_b  output  32  to ALU Src_B
alu_control  output  4  to ALU ALUControl
alu_c_in  output  1  to ALU C_in
alu_result  input  32  from ALU ALUResult (combinational)
alu_flags  input  4  from ALU ALUFlags; only bit 1 (C) is used

Behaviour:
- Clock is CLK; Reset is synchronous and active-high, sampled on the CLK rising edge.
- States: IDLE, RUN, DONE. Reset -> IDLE; word index 0; resp_result 0; resp_flags 0; resp_valid 0; carry and Z accumulator 0.
- req_ready = (state==IDLE), combinational. After reset it is 1.
- IDLE: on req_valid && req_ready, register req_a, req_op, and req_b (bitwise inverted when req_op=1). Clear resp_result. Set index 0. Go to RUN.
- RUN, word i: alu_src_a = A[i], alu_src_b = B'[i] (registered, already inverted for subtract), alu_control = 4'b0101 (ADC).
- alu_c_in: for i=0 it is req_op (add -> 0, subtract -> 1, giving A+~B+1). For i>0 it is the carry registered from word i−1.
- Each RUN edge: resp_result word i <= alu_result; carry <= alu_flags[1]; zacc <= zacc | (|alu_result), with zacc cleared at word 0.
- RUN, i = WORDS−1: at the edge, set resp_flags as follows, then go to DONE.
  - N = alu_result[31]
  - Z = ~(zacc | (|alu_result))
  - C = alu_flags[1]; for subtract, C=1 means no borrow
  - V = (A[i][31] == B'[i][31]) && (alu_result[31] != A[i][31]). V is computed here, not taken from the ALU.
- resp_valid = (state==DONE). resp_result and resp_flags are held stable while resp_valid && !resp_ready.
- DONE: on resp_ready go to IDLE. A new request is not accepted in the same cycle; req_ready rises the next cycle.
- Latency: if the request is accepted at edge E0, resp_valid is high from edge E0+WORDS. Minimum issue interval is WORDS+2 cycles.
- Outside RUN: alu_src_a = 0, alu_src_b = 0, alu_control = 4'b0100, alu_c_in = 0. The ALU bus is deterministic and idle.
- Reset mid-RUN or mid-DONE: the operation is abandoned and all registers return to reset values at that edge. No response is produced.
- req_valid in RUN/DONE is ignored (req_ready=0). Inputs req_a/req_b may change after acceptance without effect.

Test Plan:
1. WORDS=2, add 0x00000000_FFFFFFFF + 0x00000000_00000001 -> word-0 cycle alu_c_in=0, word-1 cycle alu_c_in=1. Result 0x00000001_00000000, flags 4'b0000, resp_valid 2 cycles after accept.
2. Subtract 0x0 − 0x1 -> result 0xFFFFFFFF_FFFFFFFF, flags N=1 Z=0 C=0 V=0. Word-0 cycle drives alu_src_b=0xFFFFFFFE, alu_c_in=1.
3. Add 0x7FFFFFFF_FFFFFFFF + 0x1 -> result 0x80000000_00000000, flags N=1 Z=0 C=0 V=1.
4. Subtract 0x12345678_00000005 − same value -> result 0, flags N=0 Z=1 C=1 V=0. Also check 0x1_00000000 − 0x0_00000000 gives Z=0, covering the Z accumulation across words.
5. Backpressure: hold resp_ready=0 for 3 cycles in DONE -> resp_valid, result and flags stable, req_ready=0, req_valid pulses ignored. resp_ready=1 -> IDLE next cycle, req_ready=1.
6. Assert Reset during word-0 RUN cycle -> next cycle state IDLE, req_ready=1, resp_valid=0, resp_result=0, alu_control=4'b0100. A following request completes normally.

Source files
------------

// File: rtl/alu_mw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mw_sequencer
// Brief    : Drives the shared 32-bit ALU one word per clock (LS word first)
//            to build a WORDS x 32-bit add/subtract with carry chaining and
//            full-width NZCV flags. Valid/ready request in, valid/ready out.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mw_sequencer #(
    parameter int WORDS = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [32*WORDS-1:0]   req_a,
    input  logic [32*WORDS-1:0]   req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [32*WORDS-1:0]   resp_result,
    output logic [3:0]            resp_flags,
    output logic                  busy,
    output logic [31:0]           alu_src_a,
    output logic [31:0]           alu_src_b,
    output logic [3:0]            alu_control,
    output logic                  alu_c_in,
    input  logic [31:0]           alu_result,
    input  logic [3:0]            alu_flags
);

    localparam int                 c_IDX_W    = (WORDS > 2) ? 2 : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [3:0] c_ALU_ADD = 4'b0100;
    localparam logic [3:0] c_ALU_ADC = 4'b0101;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_op;
    logic [32*WORDS-1:0]   r_a;
    logic [32*WORDS-1:0]   r_b;   // already inverted for subtract
    logic                  r_carry;
    logic                  r_zacc;
    logic [32*WORDS-1:0]   r_result;
    logic [3:0]            r_flags;

    logic [31:0]           w_a_word;
    logic [31:0]           w_b_word;
    logic                  w_first;
    logic                  w_last;
    logic                  w_zsum;
    logic                  w_v;
    logic                  w_unused_flags;

    assign w_a_word = r_a[{r_idx, 5'b0} +: 32];
    assign w_b_word = r_b[{r_idx, 5'b0} +: 32];
    assign w_first  = (r_idx == '0);
    assign w_last   = (r_idx == c_LAST_IDX);

    // Non-zero accumulator restarts at word 0 so a stale value never leaks in
    assign w_zsum   = (w_first ? 1'b0 : r_zacc) | (|alu_result);

    // Signed overflow judged from the top word operands and the ALU sum
    assign w_v      = (w_a_word[31] == w_b_word[31]) && (alu_result[31] != w_a_word[31]);

    // Only the carry flag of the ALU is consumed
    assign w_unused_flags = ^{alu_flags[3:2], alu_flags[0]};

    assign resp_result = r_result;
    assign resp_flags  = r_flags;

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, handshake outputs and ALU bus drive
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        busy         = 1'b0;
        alu_src_a    = 32'd0;
        alu_src_b    = 32'd0;
        alu_control  = c_ALU_ADD;
        alu_c_in     = 1'b0;
        case (r_state)
            c_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = c_RUN;
                end
            end
            c_RUN: begin
                busy        = 1'b1;
                alu_src_a   = w_a_word;
                alu_src_b   = w_b_word;
                alu_control = c_ALU_ADC;
                // Word 0 injects the +1 of two's-complement subtract
                alu_c_in    = w_first ? r_op : r_carry;
                if (w_last) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Operand capture, per-word result collection and flag accumulation
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_idx    <= '0;
            r_op     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_zacc   <= 1'b0;
            r_result <= '0;
            r_flags  <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_a      <= req_a;
                        r_b      <= req_op ? ~req_b : req_b;
                        r_op     <= req_op;
                        r_result <= '0;
                        r_idx    <= '0;
                        r_carry  <= 1'b0;
                        r_zacc   <= 1'b0;
                    end
                end
                c_RUN: begin
                    r_result[{r_idx, 5'b0} +: 32] <= alu_result;
                    r_carry                       <= alu_flags[1];
                    r_zacc                        <= w_zsum;
                    if (w_last) begin
                        r_flags <= {alu_result[31], ~w_zsum, alu_flags[1], w_v};
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
